// File: rtl/tdes_pass_sequencer_if.sv
`default_nettype none
// ============================================================================
// tdes_pass_sequencer_if : slave-controller and DES-core signals of the TDES
// pass sequencer (slave = sequencer side, master = environment side).
// Revision 1.0
// ============================================================================
interface tdes_pass_sequencer_if;
    logic        enable;
    logic        encryptionType;
    logic [63:0] data;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
    logic        core_start;
    logic        core_decrypt;
    logic [63:0] core_key;
    logic [63:0] core_din;
    logic [63:0] core_dout;
    logic        core_done;
    logic        busy;
    logic        outputEnable;
    logic [63:0] outputData;
    logic        error;

    modport slave (
        input  enable, encryptionType, data, key1, key2, key3, core_dout, core_done,
        output core_start, core_decrypt, core_key, core_din, busy, outputEnable,
               outputData, error
    );

    modport master (
        output enable, encryptionType, data, key1, key2, key3, core_dout, core_done,
        input  core_start, core_decrypt, core_key, core_din, busy, outputEnable,
               outputData, error
    );
endinterface
`default_nettype wire

// File: rtl/tdes_pass_sequencer.sv
`default_nettype none
// ============================================================================
// tdes_pass_sequencer : runs one shared DES core through the three TDES passes.
// Optional WAIT timeout enabled by macro TDES_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
module tdes_pass_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    tdes_pass_sequencer_if.slave        tdes_io
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic        enc_q, enc_d;
    logic [63:0] key1_q, key1_d;
    logic [63:0] key2_q, key2_d;
    logic [63:0] key3_q, key3_d;
    logic        core_decrypt_q, core_decrypt_d;
    logic [63:0] core_key_q, core_key_d;
    // core_din_q holds the latched block for pass 0 and the intermediate afterwards
    logic [63:0] core_din_q, core_din_d;
    logic        out_en_q, out_en_d;
    logic [63:0] out_data_q, out_data_d;

`ifdef TDES_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             error_q, error_d;
`endif

    // Encrypt is E-D-E with keys 1,2,3; decrypt is D-E-D with keys 3,2,1.
    function automatic logic pass_is_decrypt(input logic enc, input logic [1:0] p);
        return enc ? (p == 2'd1) : (p != 2'd1);
    endfunction

    function automatic logic [63:0] pass_key(input logic enc, input logic [1:0] p,
                                             input logic [63:0] k1, input logic [63:0] k2,
                                             input logic [63:0] k3);
        if (p == 2'd1)
            return k2;
        else if ((p == 2'd0) == enc)
            return k1;
        else
            return k3;
    endfunction

    always_comb begin
        state_d        = state_q;
        pass_d         = pass_q;
        enc_d          = enc_q;
        key1_d         = key1_q;
        key2_d         = key2_q;
        key3_d         = key3_q;
        core_decrypt_d = core_decrypt_q;
        core_key_d     = core_key_q;
        core_din_d     = core_din_q;
        out_en_d       = out_en_q;
        out_data_d     = out_data_q;
`ifdef TDES_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        error_d        = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tdes_io.enable) begin
                    state_d        = ST_ISSUE;
                    pass_d         = 2'd0;
                    enc_d          = tdes_io.encryptionType;
                    key1_d         = tdes_io.key1;
                    key2_d         = tdes_io.key2;
                    key3_d         = tdes_io.key3;
                    core_din_d     = tdes_io.data;
                    core_decrypt_d = pass_is_decrypt(tdes_io.encryptionType, 2'd0);
                    core_key_d     = pass_key(tdes_io.encryptionType, 2'd0, tdes_io.key1,
                                              tdes_io.key2, tdes_io.key3);
                    out_en_d       = 1'b0;
                    out_data_d     = '0;
`ifdef TDES_TIMEOUT_EN
                    error_d        = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef TDES_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (tdes_io.core_done) begin
                    if (pass_q != 2'd2) begin
                        pass_d         = pass_q + 2'd1;
                        core_din_d     = tdes_io.core_dout;
                        core_decrypt_d = pass_is_decrypt(enc_q, pass_q + 2'd1);
                        core_key_d     = pass_key(enc_q, pass_q + 2'd1, key1_q, key2_q, key3_q);
                        state_d        = ST_ISSUE;
                    end else begin
                        out_data_d = tdes_io.core_dout;
                        out_en_d   = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
`ifdef TDES_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q        <= ST_IDLE;
            pass_q         <= 2'd0;
            enc_q          <= 1'b0;
            key1_q         <= '0;
            key2_q         <= '0;
            key3_q         <= '0;
            core_decrypt_q <= 1'b0;
            core_key_q     <= '0;
            core_din_q     <= '0;
            out_en_q       <= 1'b0;
            out_data_q     <= '0;
`ifdef TDES_TIMEOUT_EN
            wait_cnt_q     <= '0;
            error_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            pass_q         <= pass_d;
            enc_q          <= enc_d;
            key1_q         <= key1_d;
            key2_q         <= key2_d;
            key3_q         <= key3_d;
            core_decrypt_q <= core_decrypt_d;
            core_key_q     <= core_key_d;
            core_din_q     <= core_din_d;
            out_en_q       <= out_en_d;
            out_data_q     <= out_data_d;
`ifdef TDES_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            error_q        <= error_d;
`endif
        end
    end

    assign tdes_io.core_start   = (state_q == ST_ISSUE);
    assign tdes_io.busy         = (state_q != ST_IDLE);
    assign tdes_io.core_decrypt = core_decrypt_q;
    assign tdes_io.core_key     = core_key_q;
    assign tdes_io.core_din     = core_din_q;
    assign tdes_io.outputEnable = out_en_q;
    assign tdes_io.outputData   = out_data_q;
`ifdef TDES_TIMEOUT_EN
    assign tdes_io.error        = error_q;
`else
    assign tdes_io.error        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdes_pass_sequencer.sv
`default_nettype none
// ============================================================================
// tb_tdes_pass_sequencer : randomized bench with an XOR mock DES core and a
// pass-table reference model. Timeout scenario runs when TDES_TIMEOUT_EN is set.
// Revision 1.0
// ============================================================================
module tb_tdes_pass_sequencer;

    localparam int TIMEOUT_CYCLES = 20;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b0;
    always #5 HCLK = ~HCLK;

    tdes_pass_sequencer_if bus ();

    tdes_pass_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .tdes_io (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Mock core: dout = din ^ key, done pulses mk_L cycles after the start cycle
    int          mk_L    = 16;
    bit          mk_hang = 1'b0;
    int          mk_cnt;
    logic        mock_done;
    logic        stray_done = 1'b0;
    logic [63:0] mock_dout, mk_res;
    logic        q_dec [$];
    logic [63:0] q_key [$];
    logic [63:0] q_din [$];

    assign bus.core_done = mock_done | stray_done;
    assign bus.core_dout = mock_dout;

    always @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            mock_done <= 1'b0;
            mock_dout <= '0;
            mk_cnt    <= 0;
            mk_res    <= '0;
        end else if (bus.core_start) begin
            q_dec.push_back(bus.core_decrypt);
            q_key.push_back(bus.core_key);
            q_din.push_back(bus.core_din);
            mk_res    <= bus.core_din ^ bus.core_key;
            mk_cnt    <= mk_hang ? 0 : mk_L - 1;
            mock_done <= !mk_hang && (mk_L == 1);
            mock_dout <= (!mk_hang && mk_L == 1) ? (bus.core_din ^ bus.core_key)
                                                 : {$urandom, $urandom};
        end else if (mk_cnt != 0) begin
            mk_cnt    <= mk_cnt - 1;
            mock_done <= (mk_cnt == 1);
            mock_dout <= (mk_cnt == 1) ? mk_res : {$urandom, $urandom};
        end else begin
            mock_done <= 1'b0;
            mock_dout <= {$urandom, $urandom};
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic scramble_inputs();
        bus.data           = rnd64();
        bus.key1           = rnd64();
        bus.key2           = rnd64();
        bus.key3           = rnd64();
        bus.encryptionType = 1'($urandom_range(0, 1));
    endtask

    // One full operation; noisy mode toggles enable/operands and injects a stray done in ISSUE
    task automatic run_op(input logic [63:0] d, input logic [63:0] k1, input logic [63:0] k2,
                          input logic [63:0] k3, input logic enc, input int lat,
                          input bit noisy, output logic [63:0] result);
        logic [63:0] ek [3];
        logic        ed [3];
        logic [63:0] edin [3];
        logic [63:0] expv;
        int          n;
        bit          seen;
        ek[0] = enc ? k1 : k3;
        ek[1] = k2;
        ek[2] = enc ? k3 : k1;
        for (int p = 0; p < 3; p++) ed[p] = enc ? (p == 1) : (p != 1);
        edin[0] = d;
        for (int p = 1; p < 3; p++) edin[p] = edin[p-1] ^ ek[p-1];
        expv   = edin[2] ^ ek[2];
        result = expv;
        q_dec.delete(); q_key.delete(); q_din.delete();
        mk_L = lat; mk_hang = 1'b0;

        @(negedge HCLK);
        bus.data = d; bus.key1 = k1; bus.key2 = k2; bus.key3 = k3;
        bus.encryptionType = enc; bus.enable = 1'b1;
        @(negedge HCLK);
        vectors++;
        if (bus.busy !== 1'b1 || bus.core_start !== 1'b1 || bus.error !== 1'b0 ||
            bus.outputEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL op_start: busy=%b start=%b err=%b oe=%b, want 1 1 0 0",
                     bus.busy, bus.core_start, bus.error, bus.outputEnable);
        end
        bus.enable = 1'b0;
        if (noisy) begin
            scramble_inputs();
            stray_done = 1'b1;
        end
        n = 1; seen = 1'b0;
        while (!seen && n < 4 + 3 * lat + 20) begin
            @(negedge HCLK);
            n++;
            stray_done = 1'b0;
            if (bus.outputEnable === 1'b1) seen = 1'b1;
            else if (noisy) begin
                bus.enable = 1'($urandom_range(0, 1));
                scramble_inputs();
            end
        end
        bus.enable = 1'b0;

        vectors++;
        if (!seen || n != 4 + 3 * lat) begin
            miscompares++;
            $display("FAIL op_latency: outputEnable cycle %0d (seen=%b), want %0d", n, seen, 4 + 3 * lat);
        end
        vectors++;
        if (bus.outputData !== expv) begin
            miscompares++;
            $display("FAIL op_data: got %h, want %h", bus.outputData, expv);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.error !== 1'b0 || q_dec.size() != 3) begin
            miscompares++;
            $display("FAIL op_end: busy=%b err=%b starts=%0d, want 0 0 3",
                     bus.busy, bus.error, q_dec.size());
        end
        for (int p = 0; p < 3; p++) begin
            if (p < q_dec.size()) begin
                vectors++;
                if (q_dec[p] !== ed[p] || q_key[p] !== ek[p] || q_din[p] !== edin[p]) begin
                    miscompares++;
                    $display("FAIL pass%0d: dec=%b key=%h din=%h, want dec=%b key=%h din=%h",
                             p, q_dec[p], q_key[p], q_din[p], ed[p], ek[p], edin[p]);
                end
            end
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b0;
        @(negedge HCLK);
        vectors++;
        if (bus.busy !== 1'b0 || bus.core_start !== 1'b0 || bus.outputEnable !== 1'b0 ||
            bus.error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy=%b start=%b oe=%b err=%b, want all 0",
                     bus.busy, bus.core_start, bus.outputEnable, bus.error);
        end
        vectors++;
        if (bus.outputData !== 64'd0 || bus.core_key !== 64'd0 || bus.core_din !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data: out=%h key=%h din=%h, want 0",
                     bus.outputData, bus.core_key, bus.core_din);
        end
        @(negedge HCLK);
        HRESET = 1'b1;
    endtask

    task automatic test_mock_sequence();
        logic [63:0] r;
        run_op(rnd64(), 64'h1, 64'h2, 64'h4, 1'b1, 16, 1'b0, r);
        run_op(rnd64(), 64'h1, 64'h2, 64'h4, 1'b0, 16, 1'b0, r);
    endtask

    task automatic test_random_ops();
        logic [63:0] r;
        for (int i = 0; i < 8; i++)
            run_op(rnd64(), rnd64(), rnd64(), rnd64(), 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 6)), 1'b0, r);
    endtask

    task automatic test_enable_while_busy();
        logic [63:0] r;
        for (int i = 0; i < 4; i++)
            run_op(rnd64(), rnd64(), rnd64(), rnd64(), 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 16)), 1'b1, r);
    endtask

    task automatic test_stray_done();
        logic [63:0] r;
        run_op(rnd64(), rnd64(), rnd64(), rnd64(), 1'b1, 3, 1'b0, r);
        @(negedge HCLK);
        stray_done = 1'b1;
        repeat (2) @(negedge HCLK);
        stray_done = 1'b0;
        @(negedge HCLK);
        vectors++;
        if (bus.busy !== 1'b0 || bus.outputEnable !== 1'b1 || bus.outputData !== r ||
            q_dec.size() != 3) begin
            miscompares++;
            $display("FAIL idle_done: busy=%b oe=%b out=%h starts=%0d, want 0 1 %h 3",
                     bus.busy, bus.outputEnable, bus.outputData, q_dec.size(), r);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] r;
        mk_L = 16; mk_hang = 1'b0;
        @(negedge HCLK);
        scramble_inputs();
        bus.enable = 1'b1;
        @(negedge HCLK);
        bus.enable = 1'b0;
        repeat (20) @(negedge HCLK);
        vectors++;
        if (bus.busy !== 1'b1 || q_dec.size() < 2) begin
            miscompares++;
            $display("FAIL mid_op: busy=%b starts=%0d, want busy 1 with pass1 started",
                     bus.busy, q_dec.size());
        end
        HRESET = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.outputEnable !== 1'b0 || bus.outputData !== 64'd0 ||
            bus.core_start !== 1'b0 || bus.core_key !== 64'd0 || bus.core_din !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid_op: busy=%b oe=%b out=%h start=%b key=%h din=%h, want 0",
                     bus.busy, bus.outputEnable, bus.outputData, bus.core_start,
                     bus.core_key, bus.core_din);
        end
        @(negedge HCLK);
        HRESET = 1'b1;
        run_op(rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 5, 1'b0, r);
    endtask

`ifdef TDES_TIMEOUT_EN
    task automatic test_timeout();
        logic [63:0] r;
        int          n;
        bit          seen;
        run_op(rnd64(), rnd64(), rnd64(), rnd64(), 1'b1, 2, 1'b0, r);
        mk_hang = 1'b1;
        @(negedge HCLK);
        scramble_inputs();
        bus.enable = 1'b1;
        @(negedge HCLK);
        bus.enable = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n < TIMEOUT_CYCLES + 40) begin
            @(negedge HCLK);
            n++;
            if (bus.error === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || n != TIMEOUT_CYCLES + 2) begin
            miscompares++;
            $display("FAIL timeout_cycle: error rose at cycle %0d (seen=%b), want %0d",
                     n, seen, TIMEOUT_CYCLES + 2);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.outputEnable !== 1'b0 || bus.outputData !== 64'd0) begin
            miscompares++;
            $display("FAIL timeout_state: busy=%b oe=%b out=%h, want 0 0 0",
                     bus.busy, bus.outputEnable, bus.outputData);
        end
        run_op(rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 4, 1'b0, r);
    endtask
`endif

    initial begin
        bus.enable = 1'b0;
        bus.encryptionType = 1'b0;
        bus.data = '0; bus.key1 = '0; bus.key2 = '0; bus.key3 = '0;
        test_reset();
        test_mock_sequence();
        test_random_ops();
        test_enable_while_busy();
        test_stray_done();
        test_reset_mid_op();
`ifdef TDES_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
